// File: rtl/fix_pkg.sv
// rtl/fix_pkg.sv - shared fixed-point constants, FSM states and saturation value
package fix_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int FRAC_DEF  = 3;

  localparam logic [WIDTH_DEF-1:0] SAT_ONES = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    FIN   = 2'd3
  } fix_state_t;

endpackage

// File: rtl/fix_div_step.sv
// rtl/fix_div_step.sv - one restoring-division iteration: shift in a dividend bit, compare, subtract
module fix_div_step
  import fix_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   i_r,
  input  logic             i_d_msb,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH:0]   o_r_next,
  output logic             o_q_bit
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  // Compare at full width; the difference fits WIDTH+1 bits because R < B on entry.
  assign w_shift  = {i_r, i_d_msb};
  assign w_ge     = (w_shift >= {2'b00, i_b});
  assign w_diff   = w_shift[WIDTH:0] - {1'b0, i_b};
  assign o_r_next = w_ge ? w_diff : w_shift[WIDTH:0];
  assign o_q_bit  = w_ge;

endmodule

// File: rtl/fix_div.sv
// rtl/fix_div.sv - sequential unsigned Q-format restoring divider; FIX_DIV_ROUND_EN adds round-half-up
module fix_div
  import fix_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] Quot,
  output logic             Cout,
  output logic             dz
);

  localparam int DW = WIDTH + FRAC;
  localparam int CW = $clog2(DW);

  fix_state_t r_state;
  fix_state_t w_next;

  logic [DW-1:0]    r_d;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_rem;
  logic [DW-1:0]    r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_valid;
  logic [WIDTH-1:0] r_quot;
  logic             r_cout;
  logic             r_dz;

  logic             w_d_msb;
  logic [WIDTH:0]   w_r_next;
  logic             w_q_bit;
  logic             w_dz;
  logic             w_cout;

  // Outside DIV the step sees a zero dividend bit, which is exactly the rounding compare {R,0} >= B.
  assign w_d_msb = (r_state == DIV) ? r_d[DW-1] : 1'b0;

  fix_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_r      (r_rem),
    .i_d_msb  (w_d_msb),
    .i_b      (r_b),
    .o_r_next (w_r_next),
    .o_q_bit  (w_q_bit)
  );

  assign w_dz   = (r_b == '0);
  assign w_cout = (|r_q[DW-1:WIDTH]) | w_dz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = DIV;
        end
      end
      DIV: begin
        if (r_cnt == '0) begin
`ifdef FIX_DIV_ROUND_EN
          w_next = ROUND;
`else
          w_next = FIN;
`endif
        end
      end
      ROUND:   w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_quot  <= '0;
      r_cout  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_d    <= {A, {FRAC{1'b0}}};
            r_b    <= B;
            r_rem  <= '0;
            r_q    <= '0;
            r_cnt  <= CW'(DW - 1);
            r_busy <= 1'b1;
          end
        end
        DIV: begin
          r_rem <= w_r_next;
          r_d   <= {r_d[DW-2:0], 1'b0};
          r_q   <= {r_q[DW-2:0], w_q_bit};
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
`ifdef FIX_DIV_ROUND_EN
        ROUND: begin
          r_q <= r_q + DW'(w_q_bit);
        end
`endif
        FIN: begin
          r_cout  <= w_cout;
          r_quot  <= w_cout ? {WIDTH{1'b1}} : r_q[WIDTH-1:0];
          r_dz    <= w_dz;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign valid = r_valid;
  assign Quot  = r_quot;
  assign Cout  = r_cout;
  assign dz    = r_dz;

endmodule

// File: tb/tb_fix_div.sv
// tb/tb_fix_div.sv - scoreboard bench for fix_div against an arithmetic reference model
module tb_fix_div;

`ifdef FIX_DIV_ROUND_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 12;
`endif

  typedef struct {
    logic [7:0] quot;
    logic       cout;
    logic       dz;
    int         due;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       valid;
  logic [7:0] Quot;
  logic       Cout;
  logic       dz;

  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];
  logic [9:0] last_out;

  fix_div dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .valid (valid),
    .Quot  (Quot),
    .Cout  (Cout),
    .dz    (dz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Q5.3 quotient straight from the arithmetic: (A*8)/B, optionally round half up, saturate at 0xFF.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int   q;
    if (b == 0) begin
      e.quot = 8'hFF; e.cout = 1'b1; e.dz = 1'b1;
    end else begin
`ifdef FIX_DIV_ROUND_EN
      q = (16 * a + b) / (2 * b);
`else
      q = (8 * a) / b;
`endif
      e.dz   = 1'b0;
      e.cout = (q > 255);
      e.quot = (q > 255) ? 8'hFF : q[7:0];
    end
    e.due = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("quot", Quot, e.quot);
          check("cout", Cout, e.cout);
          check("dz", dz, e.dz);
          check("latency", cyc, e.due);
          check("busy_at_valid", busy, 0);
        end
        last_out = {Quot, Cout, dz};
      end else begin
        check("hold", {Quot, Cout, dz}, last_out);
      end
    end
  end

  // Drive at a negedge with the DUT idle; returns just after the accepting edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = model(a, b);
    e.due = cyc + LAT;
    exp_q.push_back(e);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_valid();
    int k;
    for (k = 0; k < 3 * LAT; k++) begin
      @(negedge clk);
      if (valid) break;
    end
    if (k == 3 * LAT) check("valid_timeout", 0, 1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    last_out = '0;
    rst = 1'b0; start = 1'b0; A = '0; B = '0;
    #2 rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_quot", Quot, 0);
    check("rst_cout", Cout, 0);
    check("rst_dz", dz, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(8'h18, 8'h0C); wait_valid();
    issue(8'h08, 8'h18); wait_valid();
    issue(8'hFF, 8'h01); wait_valid();
    issue(8'h40, 8'h00); wait_valid();
    issue(8'h00, 8'h05); wait_valid();

    // start held high with new operands while busy must be ignored
    @(negedge clk);
    issue(8'h30, 8'h10);
    A = 8'h11; B = 8'h22; start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_valid();

    // back-to-back start in the valid cycle
    @(negedge clk);
    issue(8'h50, 8'h0A); wait_valid();
    issue(8'h21, 8'h07); wait_valid();

    // reset mid-operation aborts with no valid
    @(negedge clk);
    issue(8'h77, 8'h03);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    last_out = '0;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_outs", {Quot, Cout, dz}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    issue(8'h18, 8'h0C); wait_valid();

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      issue(a, b);
      wait_valid();
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fix_div.md
Name: fix_div

Overview:
- Sequential unsigned fixed-point divider, the inverse operation of the team's combinational Q5.3 multiplier.
- Operands A and B are both Q(WIDTH-FRAC).FRAC. The default is Q5.3.
- Result Quot = (A << FRAC) / B in the same format, with Cout flagging overflow.
- Restoring division, one quotient bit per clock. Start/valid handshake, so it drops into datapaths that already consume the multiplier's Prod/Cout pair.

Parameters:
- WIDTH, 8: operand and quotient width in bits.
- FRAC, 3: fractional bits of A, B and Quot.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only while busy=0.
- A  in  WIDTH  dividend, Q5.3.
- B  in  WIDTH  divisor, Q5.3.
- busy  out  1  high from the cycle after start is accepted until valid.
- valid  out  1  one-cycle pulse; Quot/Cout/dz are valid in that cycle.
- Quot  out  WIDTH  quotient, Q5.3, saturating.
- Cout  out  1  overflow: true quotient exceeds 2^WIDTH-1 LSBs, or B=0.
- dz  out  1  division by zero.

Behaviour:
- Interface decision: one clock domain, clock port clk. Reset port rst is asynchronous and active-high.
- Reset values: busy=0, valid=0, Quot=0, Cout=0, dz=0, FSM=IDLE, all internal registers 0.
- FSM states:
  - IDLE: on start=1, latch dividend D={A,FRAC zeros} (WIDTH+FRAC bits) and divisor B. Clear remainder R (WIDTH+1 bits) and quotient Q (WIDTH+FRAC bits). Set count=WIDTH+FRAC-1, busy=1, then go to DIV.
  - DIV, each cycle: R' = {R[WIDTH-1:0], D msb}; shift D left. If R' >= B, then R = R'-B and shift 1 into Q. Otherwise R = R' and shift 0 into Q. When count=0 go to FIN; otherwise decrement count.
  - FIN: register the outputs.
    - Cout = |Q[WIDTH+FRAC-1:WIDTH].
    - Quot = Cout ? all ones : Q[WIDTH-1:0].
    - dz = (B==0).
    - Set valid=1, busy=0, then go to IDLE.
- Latency: valid is high exactly WIDTH+FRAC+1 = 12 cycles after the edge that samples start. Throughput is one division per 12 cycles. A new start can be accepted in the cycle valid is high: state is IDLE and busy=0 then.
- B=0: still runs the full latency, for uniform timing. The result is forced to Quot=all ones, Cout=1, dz=1.
- A=0 with B!=0: Quot=0, Cout=0.
- Rounding: truncating toward zero by default.
- start while busy=1: ignored. The latched operands are unchanged.
- A and B changing after acceptance: has no effect on the result.
- Quot, Cout, dz hold their values between valid pulses. Only valid is a pulse.
- rst asserted mid-operation: immediate return to IDLE with the reset values above. No valid is produced for the aborted operation.

Optional Feature:
- Macro FIX_DIV_ROUND_EN.
- Defined:
  - FSM gains a ROUND state between DIV and FIN. ROUND computes one extra bit: r = ({R,0} >= B).
  - Q = Q + r (round half up).
  - If the increment overflows Q[WIDTH-1:0] past all ones, then Cout=1 and Quot saturates to all ones.
  - Latency becomes 13 cycles.
- Undefined: truncation, latency 12. Port list is identical in both builds.

Decomposition:
- Package fix_pkg holds:
  - the Q-format constants (WIDTH_DEF=8, FRAC_DEF=3);
  - the FSM state enum (IDLE, DIV, ROUND, FIN);
  - a saturation constant of all ones.
- The multiplier and any future fixed-point blocks share it.
- Optional sub-module fix_div_step: combinational single-iteration compare/subtract (R, D msb, B -> R_next, q_bit). It is reused by the ROUND state.

Test Plan:
- 3.0/1.5: A=0x18, B=0x0C, start -> valid at cycle 12; Quot=0x10 (2.0), Cout=0, dz=0.
- 1.0/3.0: A=0x08, B=0x18 -> Quot=0x02 (0.25). With FIX_DIV_ROUND_EN: Quot=0x03 (0.375), valid at cycle 13.
- Overflow: A=0xFF, B=0x01 -> Quot=0xFF, Cout=1, dz=0.
- Divide by zero: A=0x40, B=0x00 -> Quot=0xFF, Cout=1, dz=1, still 12-cycle latency.
- Handshake: start held high with a new A/B during busy -> ignored, first result correct. Back-to-back start in the valid cycle -> second result 12 cycles later.
- Reset mid-operation: rst pulse at cycle 5 -> busy=0 and outputs 0 immediately, no valid. Next division after release is correct.
